// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO on the processor data bus.
// Optional even-parity bit is enabled by defining UART_TX_PARITY_EN.
module uart_tx_mmio #(
  parameter int unsigned CLKS_PER_BIT = 100,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0010
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [3:0]  dbus_en_i,
  input  logic [31:0] dbus_write_addr_i,
  input  logic [31:0] dbus_write_data_i,
  input  logic [31:0] dbus_read_addr_i,
  output logic [31:0] dbus_read_data_o,
  output logic        tx_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [PTR_W:0]   occupancy;
  logic             full;
  logic             empty;
  logic             overflow_q;
  logic [CNT_W-1:0] baud_cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             parity_q;
  logic [7:0]       head;
  logic             push_hit;
  logic             push_ok;
  logic             ovf_clear;
  logic             pop;
  logic             busy;
  logic             parity_flag;
  logic             unused_bits;

  assign unused_bits = ^{dbus_en_i[3:1], dbus_write_data_i[31:8]};

  assign full      = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign occupancy = wr_ptr_q - rd_ptr_q;
  assign head      = mem[rd_ptr_q[PTR_W-1:0]];

  assign push_hit  = dbus_en_i[0] && (dbus_write_addr_i == BASE_ADDR);
  assign push_ok   = push_hit && !full;
  assign ovf_clear = dbus_en_i[0] && (dbus_write_addr_i == STATUS_ADDR) &&
                     dbus_write_data_i[2];

  // The FSM pops either from IDLE or straight out of a finished stop bit.
  assign pop  = !empty && ((state_q == S_IDLE) ||
                           ((state_q == S_STOP) && (baud_cnt_q == '0)));
  assign busy = !empty || (state_q != S_IDLE);

`ifdef UART_TX_PARITY_EN
  assign parity_flag = 1'b1;
`else
  assign parity_flag = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= dbus_write_data_i[7:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // A dropped push wins over a same-cycle clear.
      if (push_hit && full) begin
        overflow_q <= 1'b1;
      end else if (ovf_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      tx_o       <= 1'b1;
      rd_ptr_q   <= '0;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        shift_q    <= head;
        parity_q   <= ^head;
        baud_cnt_q <= CNT_RELOAD;
        tx_o       <= 1'b0;
        state_q    <= S_START;
      end else begin
        case (state_q)
          S_IDLE: begin
            tx_o <= 1'b1;
          end
          S_START: begin
            if (baud_cnt_q == '0) begin
              tx_o       <= shift_q[0];
              baud_cnt_q <= CNT_RELOAD;
              bit_idx_q  <= '0;
              state_q    <= S_DATA;
            end else begin
              baud_cnt_q <= baud_cnt_q - 1'b1;
            end
          end
          S_DATA: begin
            if (baud_cnt_q == '0) begin
              baud_cnt_q <= CNT_RELOAD;
              if (bit_idx_q != 3'd7) begin
                shift_q   <= shift_q >> 1;
                tx_o      <= shift_q[1];
                bit_idx_q <= bit_idx_q + 1'b1;
              end else begin
`ifdef UART_TX_PARITY_EN
                tx_o    <= parity_q;
                state_q <= S_PARITY;
`else
                tx_o    <= 1'b1;
                state_q <= S_STOP;
`endif
              end
            end else begin
              baud_cnt_q <= baud_cnt_q - 1'b1;
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (baud_cnt_q == '0) begin
              tx_o       <= 1'b1;
              baud_cnt_q <= CNT_RELOAD;
              state_q    <= S_STOP;
            end else begin
              baud_cnt_q <= baud_cnt_q - 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (baud_cnt_q == '0) begin
              state_q <= S_IDLE;
            end else begin
              baud_cnt_q <= baud_cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            tx_o    <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    dbus_read_data_o = '0;
    if (dbus_read_addr_i == STATUS_ADDR) begin
      dbus_read_data_o[0]    = full;
      dbus_read_data_o[1]    = busy;
      dbus_read_data_o[2]    = overflow_q;
      dbus_read_data_o[3]    = parity_flag;
      dbus_read_data_o[15:8] = 8'(occupancy);
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter on the processor data bus; it is the consumer of dbus stores to the peripheral window and drives the top-level tx_o pin.
- Sits beside the cycle-counter CSR, decodes its own addresses from the dbus write/read ports, and buffers bytes in a small FIFO.
- Serialises each byte as 8N1, LSB first, at a fixed clocks-per-bit rate.

Parameters:
- CLKS_PER_BIT, 100: clock cycles per serial bit; must be ≥2.
- FIFO_DEPTH, 16: TX FIFO entries; must be a power of two, ≥2.
- BASE_ADDR, 32'h8000_0010: TXDATA register address; STATUS register is at BASE_ADDR+4.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- dbus_en_i  input  4  byte write enables from the processor.
- dbus_write_addr_i  input  32  store address.
- dbus_write_data_i  input  32  store data.
- dbus_read_addr_i  input  32  load address.
- dbus_read_data_o  output  32  load data; combinational.
- tx_o  output  1  serial line; registered, idle high.

Behaviour:
- Reset (rst_ni low, asynchronous): tx_o=1; FSM=IDLE; FIFO empty (read and write pointers 0); overflow flag=0; baud counter and bit index 0.
- Reset asserted mid-frame: the frame is aborted, tx_o returns to 1 immediately, and buffered bytes are discarded.
- Push: on a rising edge with dbus_en_i[0]=1 and dbus_write_addr_i==BASE_ADDR:
  - if the FIFO is not full, dbus_write_data_i[7:0] is enqueued;
  - if full, the byte is dropped and overflow is set (sticky).
  - "Full" is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if a pop occurs that cycle.
- Overflow clear: a write with dbus_en_i[0]=1 to BASE_ADDR+4 and dbus_write_data_i[2]=1 clears overflow. If a dropped push coincides, set wins.
- STATUS read (dbus_read_addr_i==BASE_ADDR+4):
  - bit0 full;
  - bit1 busy (FIFO non-empty or FSM≠IDLE);
  - bit2 overflow;
  - bits[15:8] FIFO occupancy count (0..FIFO_DEPTH);
  - all other bits 0.
- TXDATA read returns 0. Any other read address returns 0. Reads have no side effects.
- Only dbus_en_i[0] qualifies writes; the other enable bits are ignored.
- FIFO: circular buffer with pointers one bit wider than log2(FIFO_DEPTH). Full = MSBs differ and low bits equal; empty = pointers equal. Pointers wrap naturally.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. If the FIFO is non-empty: pop the head into the shift register, load the baud counter with CLKS_PER_BIT-1, set tx_o<=0, go to START. A byte pushed at edge k therefore drives tx_o low from edge k+1.
  - START: when the counter reaches 0, drive tx_o<=shift[0], reload the counter, set bit index 0, go to DATA. Otherwise decrement.
  - DATA: when the counter reaches 0 and bit index <7, shift right, drive the next bit, increment the index, and reload. At index 7 with counter 0, drive tx_o<=1, reload, go to STOP.
  - STOP: when the counter reaches 0: if the FIFO is non-empty, pop and enter START directly (tx_o<=0, no idle gap); else go to IDLE.
- Each bit is held exactly CLKS_PER_BIT cycles; a frame is 10*CLKS_PER_BIT cycles.
- Simultaneous push and pop on a non-full FIFO: both take effect and occupancy is unchanged.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined: an even-parity bit (XOR of the 8 data bits) is inserted between DATA and STOP via an extra PARITY state held CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT cycles. STATUS bit3 reads 1.
- When undefined: there is no PARITY state, frames are 8N1, and STATUS bit3 reads 0.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
- After reset: store 0x55 to 0x8000_0010 -> tx_o low from the next edge for 4 cycles, then 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles; STATUS busy=1 during the frame and 0 after 40 cycles.
- Store 0x01 and 0x80 back-to-back -> two frames of 40 cycles each, no idle gap between the stop bit and the second start bit; occupancy reads 1 then 0.
- Five stores while the line is held busy -> full=1, fifth byte dropped, overflow=1; STATUS write 0x4 -> overflow=0; the first four bytes are transmitted in order.
- Deassert rst_ni mid-DATA with 2 bytes queued -> tx_o=1 asynchronously; STATUS reads 0; no further frames are sent after release.
- Reads of 0x8000_0010 and 0x8000_0020 return 0; a store with dbus_en_i=4'b1110 to TXDATA is not enqueued.
- With UART_TX_PARITY_EN defined: store 0x07 -> parity bit 1 after the data bits, frame 44 cycles; STATUS bit3=1.
